fault_vector_sequencer: RTL and testbench

//  Parametrised, clocked successor to the static true/faulty comparison bench.

---
 rtl/fault_vector_sequencer_if.sv | 35 +++
 rtl/fault_vector_sequencer.sv | 148 ++++++++++++++
 tb/tb_fault_vector_sequencer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fault_vector_sequencer_if.sv
// Bundle between the vector loader / circuit pair and the fault vector sequencer.
// load_en and start are single-cycle qualifiers with no backpressure: they act only when busy is low, at the edge where they are high.
interface fault_vector_sequencer_if #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 1,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic            load_en;
  logic [AW-1:0]   load_addr;
  logic [IN_W-1:0] load_data;
  logic [AW:0]     num_vec;
  logic            start;
  logic [IN_W-1:0] stim_out;
  logic [OUT_W-1:0] true_out;
  logic [OUT_W-1:0] fault_out;
  logic            busy;
  logic            done;
  logic            detect_pulse;
  logic [AW-1:0]   det_idx;
  logic            detected;
  logic [AW:0]     det_count;
  logic [AW-1:0]   first_det_idx;

  modport master (
    output load_en, load_addr, load_data, num_vec, start, true_out, fault_out,
    input  stim_out, busy, done, detect_pulse, det_idx, detected, det_count, first_det_idx
  );

  modport slave (
    input  load_en, load_addr, load_data, num_vec, start, true_out, fault_out,
    output stim_out, busy, done, detect_pulse, det_idx, detected, det_count, first_det_idx
  );
endinterface

// File: rtl/fault_vector_sequencer.sv
// Applies stored vectors to a true/faulty circuit pair, holds each SETTLE+1 cycles,
// and records how many vectors exposed the fault and which one did so first.
module fault_vector_sequencer #(
  parameter int IN_W   = 3,
  parameter int OUT_W  = 1,
  parameter int DEPTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fault_vector_sequencer_if.slave  bus,
  output logic [1:0]               state_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam int CW = $clog2(SETTLE + 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NW-1:0]   nvec_q, nvec_d;
  logic [IN_W-1:0] stim_q, stim_d;
  logic            pulse_q, pulse_d;
  logic [AW-1:0]   det_idx_q, det_idx_d;
  logic            detected_q, detected_d;
  logic [NW-1:0]   count_q, count_d;
  logic [AW-1:0]   first_q, first_d;

  logic [IN_W-1:0] mem [DEPTH];

  logic            busy;
  logic            mismatch;
  logic            last_vec;
  logic [AW-1:0]   idx_nx;
  logic [NW-1:0]   nvec_clamp;
  logic [IN_W-1:0] mem0_fwd;

  assign busy       = (state_q == S_APPLY);
  assign mismatch   = |(bus.true_out ^ bus.fault_out);
  assign last_vec   = (({1'b0, idx_q} + NW'(1)) == nvec_q);
  assign idx_nx     = idx_q + AW'(1);
  assign nvec_clamp = (bus.num_vec > NW'(DEPTH)) ? NW'(DEPTH) : bus.num_vec;
  // A write landing on the start edge must be seen by the first vector.
  assign mem0_fwd   = (bus.load_en && (bus.load_addr == '0)) ? bus.load_data : mem[0];

  always_ff @(posedge clk) begin
    if (bus.load_en && !busy && (int'(bus.load_addr) < DEPTH)) begin
      mem[bus.load_addr] <= bus.load_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    nvec_d     = nvec_q;
    stim_d     = stim_q;
    pulse_d    = 1'b0;
    det_idx_d  = '0;
    detected_d = detected_q;
    count_d    = count_q;
    first_d    = first_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          detected_d = 1'b0;
          count_d    = '0;
          first_d    = '0;
          idx_d      = '0;
          cnt_d      = '0;
          nvec_d     = nvec_clamp;
          if (nvec_clamp == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_APPLY;
            stim_d  = mem0_fwd;
          end
        end
      end
      S_APPLY: begin
        if (cnt_q == CW'(SETTLE)) begin
          cnt_d = '0;
          if (mismatch) begin
            pulse_d   = 1'b1;
            det_idx_d = idx_q;
            count_d   = count_q + NW'(1);
            if (!detected_q) begin
              detected_d = 1'b1;
              first_d    = idx_q;
            end
          end
          if (last_vec) begin
            state_d = S_DONE;
          end else begin
            idx_d  = idx_nx;
            stim_d = mem[idx_nx];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      nvec_q     <= '0;
      stim_q     <= '0;
      pulse_q    <= 1'b0;
      det_idx_q  <= '0;
      detected_q <= 1'b0;
      count_q    <= '0;
      first_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      nvec_q     <= nvec_d;
      stim_q     <= stim_d;
      pulse_q    <= pulse_d;
      det_idx_q  <= det_idx_d;
      detected_q <= detected_d;
      count_q    <= count_d;
      first_q    <= first_d;
    end
  end

  assign bus.stim_out      = stim_q;
  assign bus.busy          = busy;
  assign bus.done          = (state_q == S_DONE);
  assign bus.detect_pulse  = pulse_q;
  assign bus.det_idx       = det_idx_q;
  assign bus.detected      = detected_q;
  assign bus.det_count     = count_q;
  assign bus.first_det_idx = first_q;
  assign state_o           = state_q;
endmodule

// File: tb/tb_fault_vector_sequencer.sv
// Bench for fault_vector_sequencer driving a full-adder carry pair where
// the faulty copy has its A^B gate stuck at 0; vector = {Cin, A, B}.
module tb_fault_vector_sequencer;
  localparam int IN_W   = 3;
  localparam int OUT_W  = 1;
  localparam int DEPTH  = 8;
  localparam int SETTLE = 1;
  localparam int AW     = 3;
  localparam int NW     = 4;
  localparam int P      = SETTLE + 1;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] state_o;
  int cyc = 0;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [IN_W-1:0] mem_m [DEPTH];

  int              e0, nv, done_edge, exp_cnt;
  logic            exp_det;
  logic [AW-1:0]   exp_first;
  logic [IN_W-1:0] last_stim;

  fault_vector_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();

  fault_vector_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_o)
  );

  // Circuit pair: true carry vs carry with the A^B gate stuck at 0.
  assign bus.true_out  = (bus.stim_out[1] & bus.stim_out[0]) |
                         (bus.stim_out[2] & (bus.stim_out[1] ^ bus.stim_out[0]));
  assign bus.fault_out = bus.stim_out[1] & bus.stim_out[0];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic detects(input logic [2:0] v);
    logic t, f;
    t = (v[1] & v[0]) | (v[2] & (v[1] ^ v[0]));
    f = v[1] & v[0];
    return t != f;
  endfunction

  task automatic pulse_monitor();
    logic [AW-1:0] ei;
    int ec;
    forever begin
      @(negedge clk);
      if (bus.detect_pulse === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: det_idx %0d at edge %0d, none expected", bus.det_idx, cyc);
        end else begin
          ei = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          if (bus.det_idx !== ei || cyc != ec) begin
            errors++;
            $display("FAIL pulse: idx %0d edge %0d, expected idx %0d edge %0d", bus.det_idx, cyc, ei, ec);
          end
        end
      end
    end
  endtask

  task automatic load_vec(input int addr, input logic [IN_W-1:0] data);
    bus.load_en   = 1'b1;
    bus.load_addr = addr[AW-1:0];
    bus.load_data = data;
    @(negedge clk);
    bus.load_en   = 1'b0;
    mem_m[addr]   = data;
  endtask

  task automatic start_run(input int n, input logic do_load, input logic [IN_W-1:0] ld);
    nv = (n > DEPTH) ? DEPTH : n;
    if (do_load) begin
      mem_m[0]      = ld;
      bus.load_en   = 1'b1;
      bus.load_addr = '0;
      bus.load_data = ld;
    end
    bus.num_vec = n[NW-1:0];
    bus.start   = 1'b1;
    e0 = cyc + 1;
    exp_cnt = 0; exp_det = 1'b0; exp_first = '0;
    for (int k = 0; k < nv; k++) begin
      if (detects(mem_m[k])) begin
        exp_q.push_back(k[AW-1:0]);
        exp_cyc_q.push_back(e0 + (k + 1) * P);
        exp_cnt++;
        if (!exp_det) begin
          exp_det   = 1'b1;
          exp_first = k[AW-1:0];
        end
      end
    end
    done_edge = e0 + nv * P;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.load_en = 1'b0;
  endtask

  task automatic finish_run(input string name);
    int waited = 0;
    while (bus.done !== 1'b1 && waited < 200) begin
      if (nv > 0) begin
        int k;
        k = (cyc - e0) / P;
        if (k >= nv) k = nv - 1;
        checks++;
        if (bus.stim_out !== mem_m[k] || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL %s_stim: stim %0b busy %0b at edge %0d, expected stim %0b busy 1", name, bus.stim_out, bus.busy, cyc, mem_m[k]);
        end
      end
      @(negedge clk);
      waited++;
    end
    #1;
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: done %0b after %0d cycles, expected 1", name, bus.done, waited);
    end else if (cyc != done_edge) begin
      errors++;
      $display("FAIL %s_done_edge: done at edge %0d, expected %0d", name, cyc, done_edge);
    end
    if (nv > 0) last_stim = mem_m[nv-1];
    checks++;
    if (bus.stim_out !== last_stim || bus.busy !== 1'b0 || state_o !== 2'd2) begin
      errors++;
      $display("FAIL %s_end: stim %0b busy %0b state %0d, expected stim %0b busy 0 state 2", name, bus.stim_out, bus.busy, state_o, last_stim);
    end
    checks++;
    if (bus.det_count !== NW'(exp_cnt) || bus.detected !== exp_det || bus.first_det_idx !== exp_first) begin
      errors++;
      $display("FAIL %s_results: count %0d det %0b first %0d, expected count %0d det %0b first %0d", name,
               bus.det_count, bus.detected, bus.first_det_idx, exp_cnt, exp_det, exp_first);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_pulses: %0d pulses not seen, expected 0", name, exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({bus.stim_out, bus.busy, bus.done, bus.detect_pulse, bus.det_idx, bus.detected,
         bus.det_count, bus.first_det_idx, state_o} !== '0) begin
      errors++;
      $display("FAIL %s: stim %0b busy %0b done %0b pulse %0b idx %0d det %0b count %0d first %0d state %0d, expected all 0", name,
               bus.stim_out, bus.busy, bus.done, bus.detect_pulse, bus.det_idx, bus.detected,
               bus.det_count, bus.first_det_idx, state_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    last_stim = '0;
    @(negedge clk);
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_two_detect();
    load_vec(0, 3'b101);
    load_vec(1, 3'b110);
    start_run(2, 1'b0, '0);
    finish_run("two_detect");
  endtask

  task automatic test_no_detect();
    load_vec(0, 3'b011);
    load_vec(1, 3'b000);
    load_vec(2, 3'b111);
    start_run(3, 1'b0, '0);
    finish_run("no_detect");
  endtask

  task automatic test_first_idx();
    load_vec(0, 3'b011);
    load_vec(1, 3'b110);
    load_vec(2, 3'b101);
    load_vec(3, 3'b000);
    start_run(4, 1'b0, '0);
    finish_run("first_idx");
  endtask

  task automatic test_zero_and_clamp();
    start_run(0, 1'b0, '0);
    finish_run("zero_vec");
    for (int a = 0; a < DEPTH; a++) load_vec(a, IN_W'($urandom_range(0, 7)));
    start_run(12, 1'b0, '0);
    finish_run("clamp");
  endtask

  task automatic test_busy_ignore();
    load_vec(0, 3'b101);
    load_vec(1, 3'b110);
    start_run(2, 1'b0, '0);
    bus.start     = 1'b1;
    bus.num_vec   = '0;
    bus.load_en   = 1'b1;
    bus.load_addr = '0;
    bus.load_data = 3'b000;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.load_en = 1'b0;
    finish_run("busy_ignore");
    start_run(2, 1'b0, '0);
    finish_run("busy_ignore_rerun");
  endtask

  task automatic test_load_on_start();
    load_vec(1, 3'b011);
    start_run(2, 1'b1, 3'b101);
    finish_run("load_on_start");
  endtask

  task automatic test_mid_run_reset();
    load_vec(0, 3'b101);
    load_vec(1, 3'b110);
    start_run(2, 1'b0, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("mid_run_reset");
    exp_q.delete();
    exp_cyc_q.delete();
    rst_n = 1'b1;
    last_stim = '0;
    @(negedge clk);
    start_run(2, 1'b0, '0);
    finish_run("after_reset_rerun");
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(1, DEPTH);
      for (int a = 0; a < n; a++) load_vec(a, IN_W'($urandom_range(0, 7)));
      start_run(n, 1'b0, '0);
      finish_run("back_to_back");
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.num_vec   = '0;
    bus.start     = 1'b0;
    fork
      pulse_monitor();
    join_none
    @(negedge clk);
    test_reset();
    test_two_detect();
    test_no_detect();
    test_first_idx();
    test_zero_and_clamp();
    test_busy_ignore();
    test_load_on_start();
    test_mid_run_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
